// File: rtl/taus_pkg.sv
// Shared constants for the Tausworthe generator/checker pair.
// Default step shifts, mask, and checker sync-state encodings.
package taus_pkg;

    localparam int unsigned TAUS_SHIFT_L1 = 13;
    localparam int unsigned TAUS_SHIFT_L2 = 12;
    localparam int unsigned TAUS_SHIFT_R  = 19;
    localparam logic [31:0] TAUS_CONST    = 32'hffff_fffe;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

endpackage

// File: rtl/taus_step.sv
// Combinational Tausworthe step f(s).
// The generator emits its next state, so the word after w is f(w).
module taus_step #(
    parameter int unsigned SHIFT_L1 = 13,
    parameter int unsigned SHIFT_L2 = 12,
    parameter int unsigned SHIFT_R  = 19,
    parameter logic [31:0] CONST    = 32'hffff_fffe
) (
    input  logic [31:0] s,
    output logic [31:0] f
);

    // Feedback term xor masked term, all logical 32-bit shifts
    assign f = (((s << SHIFT_L1) ^ s) >> SHIFT_R)
             ^ ((s & CONST) << SHIFT_L2);

endmodule

// File: rtl/taus_checker.sv
// Self-synchronising receive checker for the Tausworthe stream.
// Seeds from received words, locks, then flywheels over bad words.
module taus_checker
    import taus_pkg::*;
#(
    parameter int unsigned SHIFT_L1 = TAUS_SHIFT_L1,
    parameter int unsigned SHIFT_L2 = TAUS_SHIFT_L2,
    parameter int unsigned SHIFT_R  = TAUS_SHIFT_R,
    parameter logic [31:0] CONST    = TAUS_CONST,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] word_count,
    output logic [1:0]       sync_state
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(LOSS_CNT + 1);

    sync_state_e   state;
    logic [31:0]   pred;
    logic [MW-1:0] match_cnt;
    logic [XW-1:0] miss_cnt;
    logic [31:0]   f_in;
    logic [31:0]   f_pred;
    logic          hit;

    taus_step #(
        .SHIFT_L1 (SHIFT_L1),
        .SHIFT_L2 (SHIFT_L2),
        .SHIFT_R  (SHIFT_R),
        .CONST    (CONST)
    ) u_step_in (
        .s (in_data),
        .f (f_in)
    );

    taus_step #(
        .SHIFT_L1 (SHIFT_L1),
        .SHIFT_L2 (SHIFT_L2),
        .SHIFT_R  (SHIFT_R),
        .CONST    (CONST)
    ) u_step_pred (
        .s (pred),
        .f (f_pred)
    );

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign hit        = (in_data == pred);
    assign sync_state = state;

    // Sync FSM, prediction register and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            locked     <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            word_count <= '0;
            pred       <= '0;
            match_cnt  <= '0;
            miss_cnt   <= '0;
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                unique case (state)
                    HUNT: begin
                        if (in_data != '0) begin
                            pred      <= f_in;
                            match_cnt <= '0;
                            state     <= SYNC;
                        end
                    end
                    SYNC: begin
                        pred <= f_in;
                        if (hit) begin
                            match_cnt <= match_cnt + MW'(1);
                            if (match_cnt + MW'(1) == MW'(LOCK_CNT)) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                miss_cnt <= '0;
                            end
                        end else begin
                            match_cnt <= '0;
                            if (in_data == '0)
                                state <= HUNT;
                        end
                    end
                    LOCKED: begin
                        word_count <= sat_inc(word_count);
                        if (hit) begin
                            pred     <= f_in;
                            miss_cnt <= '0;
                        end else begin
                            pred      <= f_pred;
                            err       <= 1'b1;
                            err_count <= sat_inc(err_count);
                            miss_cnt  <= miss_cnt + XW'(1);
                            if (miss_cnt + XW'(1) == XW'(LOSS_CNT)) begin
                                state  <= HUNT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
            if (clr_cnt) begin
                err_count  <= '0;
                word_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_taus_checker.sv
// Directed bench for taus_checker with a scoreboard of expected outputs.
// Uses CNT_W=4 so counter saturation is reachable quickly.
module tb_taus_checker;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [31:0]   in_data = '0;
    logic          clr_cnt = 1'b0;
    logic          locked;
    logic          err;
    logic [CW-1:0] err_count;
    logic [CW-1:0] word_count;
    logic [1:0]    sync_state;

    taus_checker #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err        (err),
        .err_count  (err_count),
        .word_count (word_count),
        .sync_state (sync_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    st;
        logic          lk;
        logic          er;
        logic [CW-1:0] ec;
        logic [CW-1:0] wc;
    } exp_t;

    exp_t sbq[$];

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]    m_st;
    logic [31:0]   m_pred;
    int            m_mc;
    int            m_xc;
    logic          m_er;
    logic [CW-1:0] m_ec;
    logic [CW-1:0] m_wc;
    logic [31:0]   chain;

    function automatic logic [31:0] tf(input logic [31:0] s);
        logic [31:0] a;
        logic [31:0] b;
        a = ((s << 13) ^ s) >> 19;
        b = (s & 32'hffff_fffe) << 12;
        return a ^ b;
    endfunction

    function automatic logic [CW-1:0] sinc(input logic [CW-1:0] v);
        return (v == 4'hf) ? v : v + 4'd1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic v, input logic [31:0] w,
                         input logic c, input logic r);
        if (r) begin
            m_st = 0; m_pred = 0; m_mc = 0; m_xc = 0;
            m_er = 0; m_ec = 0; m_wc = 0;
            return;
        end
        m_er = 0;
        if (v) begin
            case (m_st)
                2'd0: if (w != 0) begin
                    m_pred = tf(w); m_mc = 0; m_st = 1;
                end
                2'd1: if (w == m_pred) begin
                    m_pred = tf(w); m_mc++;
                    if (m_mc == 4) begin m_st = 2; m_xc = 0; end
                end else begin
                    m_pred = tf(w); m_mc = 0;
                    if (w == 0) m_st = 0;
                end
                default: begin
                    m_wc = sinc(m_wc);
                    if (w == m_pred) begin
                        m_pred = tf(w); m_xc = 0;
                    end else begin
                        m_pred = tf(m_pred); m_er = 1;
                        m_ec = sinc(m_ec); m_xc++;
                        if (m_xc == 3) m_st = 0;
                    end
                end
            endcase
        end
        if (c) begin m_ec = 0; m_wc = 0; end
    endtask

    task automatic step(input logic v, input logic [31:0] d,
                        input logic c, input logic r);
        exp_t e;
        rst = r; in_valid = v; in_data = d; clr_cnt = c;
        model(v, d, c, r);
        e.st = m_st; e.lk = (m_st == 2); e.er = m_er;
        e.ec = m_ec; e.wc = m_wc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            chk("sync_state", 32'(sync_state), 32'(e.st));
            chk("locked", 32'(locked), 32'(e.lk));
            chk("err", 32'(err), 32'(e.er));
            chk("err_count", 32'(err_count), 32'(e.ec));
            chk("word_count", 32'(word_count), 32'(e.wc));
        end
    endtask

    task automatic good();
        step(1'b1, chain, 1'b0, 1'b0);
        chain = tf(chain);
    endtask

    task automatic bad(input logic [31:0] m, input logic c);
        step(1'b1, chain ^ m, c, 1'b0);
        chain = tf(chain);
    endtask

    initial begin
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        chk("rst_state", 32'(sync_state), 32'd0);
        chk("rst_ecnt", 32'(err_count), 32'd0);

        // Acquire from the documented seed chain
        chain = 32'hffff_ffff;
        good();
        chk("seed_sync", 32'(sync_state), 32'd1);
        good();
        good();
        good();
        chk("pre_lock", 32'(locked), 32'd0);
        good();
        chk("lock_5th", 32'(locked), 32'd1);
        good();
        good();

        // Single corrupted word, flywheel then correct chain
        bad(32'd1, 1'b0);
        chk("one_err", 32'(err), 32'd1);
        chk("one_ecnt", 32'(err_count), 32'd1);
        good();
        chk("fly_ok", 32'(err), 32'd0);
        chk("fly_lock", 32'(locked), 32'd1);

        // Idle gap mid-lock
        for (int i = 0; i < 10; i++)
            step(1'b0, 32'hdead_beef, 1'b0, 1'b0);
        good();

        // Clear coincident with a mismatch
        bad(32'h100, 1'b1);
        chk("clr_err", 32'(err), 32'd1);
        chk("clr_ecnt", 32'(err_count), 32'd0);
        good();

        // Saturation with interleaved good words
        for (int i = 0; i < 20; i++) begin
            bad(32'h8000_0000, 1'b0);
            good();
        end
        chk("sat_ecnt", 32'(err_count), 32'hf);
        chk("sat_lock", 32'(locked), 32'd1);

        // Three consecutive misses drop lock
        step(1'b0, 32'd0, 1'b1, 1'b0);
        bad(32'h2, 1'b0);
        bad(32'h4, 1'b0);
        chk("miss2_lock", 32'(locked), 32'd1);
        bad(32'h8, 1'b0);
        chk("miss3_ecnt", 32'(err_count), 32'd3);
        chk("miss3_lock", 32'(locked), 32'd0);
        good();
        chk("reseed", 32'(sync_state), 32'd1);

        // Zero word drops SYNC to HUNT, zeros ignored in HUNT
        step(1'b1, 32'd0, 1'b0, 1'b0);
        chk("zero_hunt", 32'(sync_state), 32'd0);
        step(1'b1, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'd0, 1'b0, 1'b0);
        chk("zero_stay", 32'(sync_state), 32'd0);

        // Relock, dirty the counters, then reset
        for (int i = 0; i < 5; i++)
            good();
        bad(32'h10, 1'b0);
        good();
        step(1'b1, chain, 1'b0, 1'b1);
        chk("rst_lock", 32'(locked), 32'd0);
        chk("rst_wcnt", 32'(word_count), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
